imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot loader: default parameters, FSM state encoding,
// and a helper that identifies the states in which a frame is in progress.
package imem_loader_pkg;

  localparam int         IMEM_WORDS_DEF     = 1024;
  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
  localparam int         TIMEOUT_CYCLES_DEF = 100000;

  typedef enum logic [2:0] {
    SYNC,
    LEN0,
    LEN1,
    DATA,
    CHK,
    RUN,
    ERR
  } loader_state_t;

  function automatic logic in_frame(input loader_state_t s);
    return s inside {LEN0, LEN1, DATA, CHK};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in from the UART receiver and word write port out to instruction memory.
// The loader takes the slave side; the surrounding system or a bench takes the master side.
interface imem_loader_if #(
  parameter int IMEM_AW = 10
);

  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Frame-based program loader: SYNC, LEN_LO, LEN_HI, 4*N data bytes, XOR checksum.
// Writes little-endian words to imem and holds the core in reset until a frame verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         IMEM_WORDS     = IMEM_WORDS_DEF,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         core_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t      r_state;
  loader_state_t      w_state_next;

  logic [15:0]        r_len;
  logic [1:0]         r_lane;
  logic [23:0]        r_asm;
  logic [7:0]         r_chk;
  logic [IMEM_AW-1:0] r_word_idx;
  logic [TW-1:0]      r_timer;

  logic               r_we;
  logic [IMEM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               r_core_reset;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic               w_byte;
  logic               w_sync_hit;
  logic               w_frame_start;
  logic [15:0]        w_len_full;
  logic               w_len_bad;
  logic               w_last_word;
  logic               w_timeout;

  assign w_byte        = bus.rx_valid;
  assign w_sync_hit    = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_frame_start = w_sync_hit && (r_state inside {SYNC, RUN});
  assign w_len_full    = {bus.rx_data, r_len[7:0]};
  assign w_len_bad     = (w_len_full == 16'd0) || (int'(w_len_full) > IMEM_WORDS);
  assign w_last_word   = (r_lane == 2'd3) && (16'(r_word_idx) == r_len - 16'd1);
  assign w_timeout     = !bus.rx_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= SYNC;
    else       r_state <= w_state_next;
  end

  // NOTE: w_state_next gets its default before the case so every path assigns it; otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SYNC: if (w_sync_hit) w_state_next = LEN0;
      LEN0: begin
        if (w_byte)         w_state_next = LEN1;
        else if (w_timeout) w_state_next = ERR;
      end
      LEN1: begin
        if (w_byte)         w_state_next = w_len_bad ? ERR : DATA;
        else if (w_timeout) w_state_next = ERR;
      end
      DATA: begin
        if (w_byte) begin
          if (w_last_word)  w_state_next = CHK;
        end else if (w_timeout) begin
          w_state_next = ERR;
        end
      end
      CHK: begin
        if (w_byte)         w_state_next = (bus.rx_data == r_chk) ? RUN : ERR;
        else if (w_timeout) w_state_next = ERR;
      end
      RUN:     if (w_sync_hit) w_state_next = LEN0;
      ERR:     w_state_next = SYNC;
      default: w_state_next = SYNC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len        <= '0;
      r_lane       <= '0;
      r_asm        <= '0;
      r_chk        <= '0;
      r_word_idx   <= '0;
      r_timer      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_busy       <= in_frame(w_state_next);
      r_done       <= (w_state_next == RUN);
      r_core_reset <= (w_state_next != RUN);

      if (w_state_next == ERR) r_error <= 1'b1;
      else if (w_frame_start)  r_error <= 1'b0;

      // Idle-cycle timer only runs while a frame is open; any accepted byte restarts it.
      if (in_frame(r_state) && !w_byte) r_timer <= r_timer + TW'(1);
      else                              r_timer <= '0;

      if (w_frame_start) begin
        r_chk      <= '0;
        r_word_idx <= '0;
        r_lane     <= '0;
      end

      if (r_state == LEN0 && w_byte) r_len[7:0]  <= bus.rx_data;
      if (r_state == LEN1 && w_byte) r_len[15:8] <= bus.rx_data;

      if (r_state == DATA && w_byte) begin
        r_chk  <= r_chk ^ bus.rx_data;
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0: r_asm[7:0]   <= bus.rx_data;
          2'd1: r_asm[15:8]  <= bus.rx_data;
          2'd2: r_asm[23:16] <= bus.rx_data;
          default: begin
            r_we       <= 1'b1;
            r_addr     <= r_word_idx;
            r_wdata    <= {bus.rx_data, r_asm};
            r_word_idx <= r_word_idx + IMEM_AW'(1);
          end
        endcase
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign core_reset     = r_core_reset;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, bad checksum, length limits,
// idle timeout, reload while running and reset in the middle of a frame.
module tb_imem_loader;

  localparam int IMEM_WORDS = 1024;
  localparam int AW         = 10;
  localparam int TIMEOUT    = 16;

  logic clk = 1'b0;
  logic reset;
  logic core_reset, busy, done, error;

  imem_loader_if #(.IMEM_AW(AW)) bus ();

  imem_loader #(
    .IMEM_WORDS    (IMEM_WORDS),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .core_reset(core_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    byte_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [3:0]    st;

  assign st = {core_reset, busy, done, error};

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa_q.push_back(bus.imem_addr);
      wd_q.push_back(bus.imem_wdata);
    end
  end

  task automatic tick(input logic v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream();
    foreach (byte_q[i]) tick(1'b1, byte_q[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00);
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0, 8'h00);
    checks++;
    if ({st, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {4'b1000, 1'b0, 10'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values: st=%b we=%b addr=%0h wdata=%h, expected st=1000 we=0 addr=0 wdata=0",
               st, bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_normal_load();
    logic [AW-1:0] exp_a[3] = '{10'd0, 10'd1, 10'd2};
    logic [31:0]   exp_d[3] = '{32'h0000_0013, 32'h0010_0093, 32'h0000_006F};
    do_reset();
    tick(1'b1, 8'hA5);
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL normal_after_sync: st=%b expected 1100", st);
    end
    byte_q = {8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_stream();
    checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 10'd0, 32'h0000_0013}) begin
      errors++;
      $display("FAIL normal_first_write: we=%b addr=%0h wdata=%h expected we=1 addr=0 wdata=00000013",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    byte_q = {8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stream();
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL normal_before_chk: st=%b expected 1100", st);
    end
    tick(1'b1, 8'hFF);
    checks++;
    if (st !== 4'b0010) begin
      errors++;
      $display("FAIL normal_after_chk: st=%b expected 0010", st);
    end
    checks++;
    if (wa_q.size() !== 3) begin
      errors++;
      $display("FAIL normal_write_count: got %0d expected 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({wa_q[i], wd_q[i]} !== {exp_a[i], exp_d[i]}) begin
          errors++;
          $display("FAIL normal_write%0d: addr=%0h data=%h expected addr=%0h data=%h",
                   i, wa_q[i], wd_q[i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    byte_q = {8'hA5, 8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'hFE};
    send_stream();
    checks++;
    if (st !== 4'b1001) begin
      errors++;
      $display("FAIL badchk_status: st=%b expected 1001", st);
    end
    checks++;
    if (wa_q.size() !== 3) begin
      errors++;
      $display("FAIL badchk_write_count: got %0d expected 3", wa_q.size());
    end
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    checks++;
    if (st !== 4'b1001) begin
      errors++;
      $display("FAIL badchk_sticky: st=%b expected 1001", st);
    end
    tick(1'b1, 8'hA5);
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL badchk_resync: st=%b expected 1100", st);
    end
  endtask

  task automatic test_len_checks();
    do_reset();
    byte_q = {8'hA5, 8'h00, 8'h00};
    send_stream();
    checks++;
    if (st !== 4'b1001) begin
      errors++;
      $display("FAIL len_zero: st=%b expected 1001", st);
    end
    tick(1'b0, 8'h00);
    byte_q = {8'hA5, 8'h01, 8'h04};
    send_stream();
    checks++;
    if (st !== 4'b1001) begin
      errors++;
      $display("FAIL len_over: st=%b expected 1001", st);
    end
    tick(1'b0, 8'h00);
    byte_q = {8'hA5, 8'h00, 8'h04};
    send_stream();
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL len_max_accepted: st=%b expected 1100", st);
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL len_no_writes: got %0d writes expected 0", wa_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    byte_q = {8'hA5, 8'h03, 8'h00, 8'h13, 8'h00};
    send_stream();
    repeat (TIMEOUT - 1) tick(1'b0, 8'h00);
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_early: st=%b expected 1100", st);
    end
    tick(1'b0, 8'h00);
    checks++;
    if (st !== 4'b1001) begin
      errors++;
      $display("FAIL timeout_fire: st=%b expected 1001", st);
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_no_writes: got %0d writes expected 0", wa_q.size());
    end
  endtask

  task automatic test_reload();
    do_reset();
    byte_q = {8'hA5, 8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_stream();
    tick(1'b1, 8'h13);
    checks++;
    if (st !== 4'b0010) begin
      errors++;
      $display("FAIL reload_ignore_byte: st=%b expected 0010", st);
    end
    tick(1'b1, 8'hA5);
    checks++;
    if (st !== 4'b1100) begin
      errors++;
      $display("FAIL reload_sync: st=%b expected 1100", st);
    end
    byte_q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_stream();
    checks++;
    if (st !== 4'b0010) begin
      errors++;
      $display("FAIL reload_done: st=%b expected 0010", st);
    end
    checks++;
    if (wa_q.size() !== 4) begin
      errors++;
      $display("FAIL reload_write_count: got %0d expected 4", wa_q.size());
    end else begin
      checks++;
      if ({wa_q[3], wd_q[3]} !== {10'd0, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL reload_write: addr=%0h data=%h expected addr=0 data=deadbeef", wa_q[3], wd_q[3]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_stream();
    reset = 1'b1;
    tick(1'b0, 8'h00);
    checks++;
    if ({st, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {4'b1000, 1'b0, 10'd0, 32'd0}) begin
      errors++;
      $display("FAIL midreset_values: st=%b we=%b addr=%0h wdata=%h, expected st=1000 we=0 addr=0 wdata=0",
               st, bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
    byte_q = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_stream();
    checks++;
    if (st !== 4'b0010) begin
      errors++;
      $display("FAIL midreset_reload_done: st=%b expected 0010", st);
    end
    checks++;
    if (wa_q.size() !== 1) begin
      errors++;
      $display("FAIL midreset_write_count: got %0d expected 1", wa_q.size());
    end else begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== {10'd0, 32'h1234_5678}) begin
        errors++;
        $display("FAIL midreset_write: addr=%0h data=%h expected addr=0 data=12345678", wa_q[0], wd_q[0]);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_normal_load();
    test_bad_checksum();
    test_len_checks();
    test_timeout();
    test_reload();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
